wbu_stage: RTL and testbench

Write-back stage directly downstream of the execute unit. It captures one completed instruction per valid/ready handshake into a single-entry pipeline register. On commit it drives the register-file and CSR write ports and hands the next PC to the fetch unit. A one-entry buffer with same-cycle fill/drain decouples execute from fetch back-pressure.

---
 rtl/wbu_stage.sv | 125 ++++++++++++
 tb/tb_wbu_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wbu_stage.sv
// Write-back stage: a single-entry pipeline register that commits RF/CSR/trap writes and hands the next PC to fetch.
// Optional performance counters (o_instret, o_stall_cyc) are built when WBU_PERF_EN is defined.
module wbu_stage #(
  parameter int XLEN        = 32,
  parameter int RF_AW       = 5,
  parameter int ECALL_CAUSE = 11
`ifdef WBU_PERF_EN
  ,
  parameter int PERF_W      = 64
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [XLEN-1:0]  i_res,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_pc_next,
  input  logic [RF_AW-1:0] i_rd,
  input  logic             i_rf_wen,
  input  logic             i_csr_wen,
  input  logic [11:0]      i_csr_addr,
  input  logic [XLEN-1:0]  i_csr_wdata,
  input  logic             i_ecall,
  output logic             o_rf_wen,
  output logic [RF_AW-1:0] o_rf_waddr,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic             o_csr_wen,
  output logic [11:0]      o_csr_waddr,
  output logic [XLEN-1:0]  o_csr_wdata,
  output logic             o_trap_wen,
  output logic [XLEN-1:0]  o_mepc,
  output logic [XLEN-1:0]  o_mcause,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [XLEN-1:0]  o_pc_next
`ifdef WBU_PERF_EN
  ,
  output logic [PERF_W-1:0] o_instret,
  output logic [PERF_W-1:0] o_stall_cyc
`endif
);

  logic             full_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_next_q;
  logic [XLEN-1:0]  res_q;
  logic [RF_AW-1:0] rd_q;
  logic             rf_wen_q;
  logic             csr_wen_q;
  logic [11:0]      csr_addr_q;
  logic [XLEN-1:0]  csr_wdata_q;
  logic             ecall_q;

  logic accept;
  logic commit;

  // Ready while empty, or while the held entry drains this same cycle.
  assign o_pre_ready = ~full_q | i_post_ready;
  assign accept      = i_pre_valid & o_pre_ready;
  assign commit      = full_q & i_post_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q      <= 1'b0;
      pc_q        <= '0;
      pc_next_q   <= '0;
      res_q       <= '0;
      rd_q        <= '0;
      rf_wen_q    <= 1'b0;
      csr_wen_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      ecall_q     <= 1'b0;
    end else if (accept) begin
      full_q      <= 1'b1;
      pc_q        <= i_pc;
      pc_next_q   <= i_pc_next;
      res_q       <= i_res;
      rd_q        <= i_rd;
      rf_wen_q    <= i_rf_wen;
      csr_wen_q   <= i_csr_wen;
      csr_addr_q  <= i_csr_addr;
      csr_wdata_q <= i_csr_wdata;
      ecall_q     <= i_ecall;
    end else if (commit) begin
      full_q      <= 1'b0;
    end
  end

  assign o_post_valid = full_q;
  assign o_pc_next    = pc_next_q;

  // x0 is hardwired to zero, so its writes never leave the stage.
  assign o_rf_wen    = commit & rf_wen_q & (rd_q != '0);
  assign o_rf_waddr  = rd_q;
  assign o_rf_wdata  = res_q;
  assign o_csr_wen   = commit & csr_wen_q;
  assign o_csr_waddr = csr_addr_q;
  assign o_csr_wdata = csr_wdata_q;
  assign o_trap_wen  = commit & ecall_q;
  assign o_mepc      = pc_q;
  assign o_mcause    = XLEN'(ECALL_CAUSE);

`ifdef WBU_PERF_EN
  logic [PERF_W-1:0] instret_q;
  logic [PERF_W-1:0] stall_cyc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      instret_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (commit)
        instret_q <= instret_q + 1'b1;
      if (full_q & ~i_post_ready)
        stall_cyc_q <= stall_cyc_q + 1'b1;
    end
  end

  assign o_instret   = instret_q;
  assign o_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_wbu_stage.sv
// Scoreboard bench for wbu_stage: the driver queues accepted instructions, a negedge monitor checks every cycle.
module tb_wbu_stage;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        ecall;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_pre_valid = 1'b0;
  logic        o_pre_ready;
  logic [31:0] i_res = '0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_pc_next = '0;
  logic [4:0]  i_rd = '0;
  logic        i_rf_wen = 1'b0;
  logic        i_csr_wen = 1'b0;
  logic [11:0] i_csr_addr = '0;
  logic [31:0] i_csr_wdata = '0;
  logic        i_ecall = 1'b0;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_csr_wen;
  logic [11:0] o_csr_waddr;
  logic [31:0] o_csr_wdata;
  logic        o_trap_wen;
  logic [31:0] o_mepc;
  logic [31:0] o_mcause;
  logic        o_post_valid;
  logic        i_post_ready = 1'b0;
  logic [31:0] o_pc_next;
`ifdef WBU_PERF_EN
  logic [63:0] o_instret;
  logic [63:0] o_stall_cyc;
`endif

  int   errors = 0;
  int   checks = 0;
  int   n_txn  = 0;
  txn_t sb[$];
  longint n_commit = 0;
  longint n_stall  = 0;

  wbu_stage dut (
    .clock(clock), .reset(reset),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_res(i_res), .i_pc(i_pc), .i_pc_next(i_pc_next), .i_rd(i_rd),
    .i_rf_wen(i_rf_wen), .i_csr_wen(i_csr_wen), .i_csr_addr(i_csr_addr),
    .i_csr_wdata(i_csr_wdata), .i_ecall(i_ecall),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_csr_wen(o_csr_wen), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
    .o_trap_wen(o_trap_wen), .o_mepc(o_mepc), .o_mcause(o_mcause),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready), .o_pc_next(o_pc_next)
`ifdef WBU_PERF_EN
    , .o_instret(o_instret), .o_stall_cyc(o_stall_cyc)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.res       = $urandom;
    t.pc        = $urandom & 32'hFFFF_FFFC;
    t.pc_next   = $urandom & 32'hFFFF_FFFC;
    t.rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    t.rf_wen    = 1'($urandom);
    t.csr_wen   = ($urandom_range(0, 3) == 0);
    t.csr_addr  = 12'($urandom);
    t.csr_wdata = $urandom;
    t.ecall     = ($urandom_range(0, 5) == 0);
    return t;
  endfunction

  // Present one cycle of stimulus; an instruction counts as accepted when offered while the model is empty
  // (the monitor has already removed any entry that drained this cycle).
  task automatic drive(input txn_t t, input bit v, input bit pr);
    i_pre_valid = v;
    i_post_ready = pr;
    i_res = t.res; i_pc = t.pc; i_pc_next = t.pc_next; i_rd = t.rd;
    i_rf_wen = t.rf_wen; i_csr_wen = t.csr_wen; i_csr_addr = t.csr_addr;
    i_csr_wdata = t.csr_wdata; i_ecall = t.ecall;
    @(posedge clock);
    if (!reset && v && sb.size() == 0)
      sb.push_back(t);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    sb.delete();
    #1;
    reset = 1'b0;
  endtask

  // Monitor: expected occupancy is the scoreboard depth; a commit pops and checks the write-back strobes.
  always @(negedge clock) begin
    bit   full;
    bit   commit;
    bit   exp_rf;
    txn_t t;
    if (reset) begin
      n_commit = 0;
      n_stall  = 0;
    end else begin
      full   = (sb.size() != 0);
      commit = full && i_post_ready;
      chk("post_valid", 64'(o_post_valid), 64'(full));
      chk("pre_ready", 64'(o_pre_ready), 64'(!full || i_post_ready));
`ifdef WBU_PERF_EN
      chk("instret", o_instret, 64'(n_commit));
      chk("stall_cyc", o_stall_cyc, 64'(n_stall));
      if (full && !i_post_ready) n_stall++;
      if (commit) n_commit++;
`endif
      if (full)
        chk("pc_next", 64'(o_pc_next), 64'(sb[0].pc_next));
      if (commit) begin
        t = sb.pop_front();
        n_txn++;
        exp_rf = t.rf_wen && (t.rd != 5'd0);
        chk("rf_wen", 64'(o_rf_wen), 64'(exp_rf));
        if (exp_rf) begin
          chk("rf_waddr", 64'(o_rf_waddr), 64'(t.rd));
          chk("rf_wdata", 64'(o_rf_wdata), 64'(t.res));
        end
        chk("csr_wen", 64'(o_csr_wen), 64'(t.csr_wen));
        if (t.csr_wen) begin
          chk("csr_waddr", 64'(o_csr_waddr), 64'(t.csr_addr));
          chk("csr_wdata", 64'(o_csr_wdata), 64'(t.csr_wdata));
        end
        chk("trap_wen", 64'(o_trap_wen), 64'(t.ecall));
        if (t.ecall) begin
          chk("mepc", 64'(o_mepc), 64'(t.pc));
          chk("mcause", 64'(o_mcause), 64'd11);
        end
        $display("txn %0d: pc_next=%08h rd=%0d rf_wen=%0b res=%08h csr=%0b ecall=%0b", n_txn,
                 t.pc_next, t.rd, exp_rf, t.res, t.csr_wen, t.ecall);
      end else begin
        chk("idle_strobes", 64'({o_rf_wen, o_csr_wen, o_trap_wen}), 64'd0);
      end
    end
  end

  initial begin
    txn_t t;
    txn_t t2;
    txn_t idle;
    idle = '{default: '0};
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic write to x5, then a suppressed write to x0.
    t = idle; t.rd = 5'd5; t.rf_wen = 1'b1; t.res = 32'h1234; t.pc_next = 32'h8000_0004;
    drive(t, 1, 1);
    t = idle; t.rd = 5'd0; t.rf_wen = 1'b1; t.res = 32'hDEAD; t.pc_next = 32'h8000_0008;
    drive(t, 1, 1);
    drive(idle, 0, 1);

    // Back-pressure: second instruction is held off until the first drains.
    t = idle; t.rd = 5'd7; t.rf_wen = 1'b1; t.res = 32'hAAAA_0001; t.pc_next = 32'h8000_0010;
    t2 = idle; t2.rd = 5'd8; t2.rf_wen = 1'b1; t2.res = 32'hBBBB_0002; t2.pc_next = 32'h8000_0014;
    drive(t, 1, 0);
    repeat (3) drive(t2, 1, 0);
    drive(t2, 1, 1);
    drive(idle, 0, 1);

    // Ecall together with a CSR write.
    t = idle; t.ecall = 1'b1; t.pc = 32'h8000_0100; t.pc_next = 32'h8000_0800;
    t.csr_wen = 1'b1; t.csr_addr = 12'h305; t.csr_wdata = 32'h0000_1000;
    drive(t, 1, 1);
    drive(idle, 0, 1);

    // Reset while holding an entry drops it.
    t = rand_txn();
    drive(t, 1, 0);
    drive(t, 0, 0);
    do_reset();
    drive(idle, 0, 0);

    // Ten back-to-back commits followed by four stalled cycles.
    do_reset();
    for (int i = 0; i < 10; i++) drive(rand_txn(), 1, 1);
    repeat (4) drive(idle, 0, 0);
    drive(idle, 0, 1);

    // Random traffic with random fetch back-pressure.
    for (int i = 0; i < 400; i++)
      drive(rand_txn(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6);

    for (int i = 0; i < 4; i++) drive(idle, 0, 1);
    @(negedge clock);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
